// File: rtl/or16_arb_pkg.sv
// Shared sizing and reset constants for the OR16 arbiter slice.
// Only the grant-index helper lives here; no logic state.
package or16_arb_pkg;

  localparam int ARB_NREQ = 4;
  localparam int ARB_WIDTH = 16;
  localparam int ARB_ID_W = 2;
  // Reset pointer of 3 makes requester 0 the first in the search order.
  localparam logic [ARB_ID_W-1:0] ARB_PTR_RST = 2'd3;

  function automatic logic [ARB_ID_W-1:0] onehot_to_idx(input logic [ARB_NREQ-1:0] oh);
    logic [ARB_ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_NREQ; i++) begin
      if (oh[i]) idx = ARB_ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/or16_arbiter_gates.sv
// Gate library used by the OR16 datapath: 2-input OR, 8-way OR reduce, 16-bit bitwise OR.
// Purely combinational, no latency, no flow control.
module student_or (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(~a & ~b);
endmodule

module student_or8way (
  input  logic [7:0] d,
  output logic       y
);
  logic [3:0] l1;
  logic [1:0] l2;

  student_or u_l1_0 (.a(d[0]), .b(d[1]), .y(l1[0]));
  student_or u_l1_1 (.a(d[2]), .b(d[3]), .y(l1[1]));
  student_or u_l1_2 (.a(d[4]), .b(d[5]), .y(l1[2]));
  student_or u_l1_3 (.a(d[6]), .b(d[7]), .y(l1[3]));
  student_or u_l2_0 (.a(l1[0]), .b(l1[1]), .y(l2[0]));
  student_or u_l2_1 (.a(l1[2]), .b(l1[3]), .y(l2[1]));
  student_or u_l3   (.a(l2[0]), .b(l2[1]), .y(y));
endmodule

module student_or16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);
  for (genvar k = 0; k < 16; k++) begin : g_bit
    student_or u_or (.a(a[k]), .b(b[k]), .y(y[k]));
  end
endmodule

// File: rtl/or16_arbiter_rr.sv
// Four-way round-robin grant, search starts at ptr+1 and wraps; gnt is one-hot or zero.
// Combinational; en low (stall or reset) forces gnt to zero.
module rr_arbiter4
  import or16_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  input  logic       en,
  output logic [3:0] gnt
);
  logic [1:0] idx;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    gnt = '0;
    idx = '0;
    if (en) begin
      for (int k = ARB_NREQ; k >= 1; k--) begin
        idx = ptr + k[1:0];
        if (req[idx]) gnt = 4'b0001 << idx;
      end
    end
  end
endmodule

// File: rtl/or16_arbiter.sv
// Shares one 16-bit OR unit among four requesters via round-robin; result registered.
// Latency 1 cycle grant-to-rsp_valid; rsp_valid && !rsp_ready stalls grants and holds the response.
module or16_arbiter
  import or16_arb_pkg::*;
#(
  parameter int NREQ  = ARB_NREQ,
  parameter int WIDTH = ARB_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   a_bus,
  input  logic [NREQ*WIDTH-1:0]   b_bus,
  output logic [NREQ-1:0]         gnt,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ARB_ID_W-1:0]     rsp_id,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    rsp_any
);
  logic                accept;
  logic [ARB_ID_W-1:0] ptr;
  logic [ARB_ID_W-1:0] gnt_id;
  logic [WIDTH-1:0]    a_sel;
  logic [WIDTH-1:0]    b_sel;
  logic [WIDTH-1:0]    or_res;
  logic                any_lo;
  logic                any_hi;
  logic                any_res;

  assign accept = ~(rsp_valid & ~rsp_ready);

  rr_arbiter4 u_rr (
    .req (req),
    .ptr (ptr),
    .en  (accept & ~rst),
    .gnt (gnt)
  );

  assign gnt_id = onehot_to_idx(gnt);

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        a_sel = a_bus[i*WIDTH +: WIDTH];
        b_sel = b_bus[i*WIDTH +: WIDTH];
      end
    end
  end

  student_or16 u_or16 (.a(a_sel), .b(b_sel), .y(or_res));

  student_or8way u_any_lo (.d(or_res[7:0]),  .y(any_lo));
  student_or8way u_any_hi (.d(or_res[15:8]), .y(any_hi));
  student_or     u_any    (.a(any_lo), .b(any_hi), .y(any_res));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_any   <= 1'b0;
      ptr       <= ARB_PTR_RST;
    end else if (gnt != '0) begin
      rsp_valid <= 1'b1;
      rsp_data  <= or_res;
      rsp_id    <= gnt_id;
      rsp_any   <= any_res;
      ptr       <= gnt_id;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: doc/or16_arbiter.md
OR16_ARBITER -- requirements
Module: or16_arbiter

Interface
REQ-001 The block SHALL take parameter NREQ, default 4: number of requesters sharing the OR unit, fixed to 4 in this revision.
REQ-002 The block SHALL take parameter WIDTH, default 16: operand and result width, fixed to 16.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port req, input, 4: request from requester i on bit i.
REQ-006 The block SHALL have port a_bus, input, 64: operand A of requester i on bits [16i+15:16i].
REQ-007 The block SHALL have port b_bus, input, 64: operand B of requester i on bits [16i+15:16i].
REQ-008 The block SHALL have port gnt, output, 4: one-hot combinational grant; its operands are consumed at the next rising edge.
REQ-009 The block SHALL have port rsp_valid, output, 1: response register holds a valid result.
REQ-010 The block SHALL have port rsp_ready, input, 1: the consumer accepts the response this cycle.
REQ-011 The block SHALL have port rsp_id, output, 2: index of the requester that owns the response.
REQ-012 The block SHALL have port rsp_data, output, 16: bitwise OR of the granted A and B operands.
REQ-013 The block SHALL have port rsp_any, output, 1: high when any bit of rsp_data is 1.

Function
REQ-014 The block SHALL assert accept = !rsp_valid || rsp_ready.
REQ-015 The gnt output SHALL be zero whenever accept is low or req is zero.
REQ-016 Otherwise, gnt SHALL select exactly one requester, by round-robin starting at ptr+1 mod 4, where ptr is the last granted index.
REQ-017 On a rising edge with gnt nonzero, the block SHALL load the following: rsp_data gets A|B of the granted requester; rsp_id gets its index; rsp_any gets the OR-reduction of that result; rsp_valid gets 1; ptr gets the granted index.
REQ-018 On a rising edge with gnt zero and rsp_valid && rsp_ready, the block SHALL clear rsp_valid; rsp_data, rsp_id and rsp_any SHALL hold.
REQ-019 While rsp_valid && !rsp_ready, the block SHALL hold rsp_data, rsp_id, rsp_any and ptr stable, and SHALL drive gnt zero (back-pressure stall).
REQ-020 Latency SHALL be 1 cycle from the grant cycle to rsp_valid.
REQ-021 With rsp_ready held high, the block SHALL sustain 1 grant and 1 response per cycle, with no bubble.
REQ-022 Each requester SHALL hold req and its operands stable until it sees its gnt bit high; a request deasserted before grant is dropped without error.
REQ-023 A requester that keeps req high after being granted SHALL be serviced again only after every other active requester has been granted once; with 4 active requesters the worst-case wait is 3 grants.
REQ-024 A single active requester SHALL be granted on every accepting cycle.
REQ-025 When ptr is 3, the round-robin search order SHALL wrap to 0, 1, 2, 3.
REQ-026 The block SHALL perform no arithmetic; result bit k SHALL be a[k] OR b[k], and no carry or width growth SHALL occur.

Reset
REQ-027 Asserting rst SHALL, immediately and independent of clk, set rsp_valid=0, rsp_data=16'h0000, rsp_id=0, rsp_any=0 and ptr=3, so that requester 0 is first priority.
REQ-028 A response pending when rst asserts SHALL be discarded, and an in-flight grant SHALL be lost.
REQ-029 The gnt output SHALL be zero while rst is high.
REQ-030 The first grant SHALL be possible in the first cycle after rst deasserts.

Structure
REQ-031 NREQ, WIDTH, the ID width (2) and the ptr reset value SHALL reside in a shared package, or16_arb_pkg.
REQ-032 The datapath SHALL be built from existing gates only: one student_or16 instance computes A|B of the muxed operands, and two student_or8way instances plus one student_or compute rsp_any.
REQ-033 No built-in OR operator SHALL be used in the datapath.
REQ-034 The round-robin grant logic SHALL be one sub-module, rr_arbiter4, with inputs req[3:0], ptr[1:0] and en, and output gnt[3:0].

Verification
REQ-035 Reset scenario: after rst pulses, req=4'b1111 and rsp_ready=1 SHALL produce grant order 0,1,2,3,0 on consecutive cycles, and rsp_id SHALL follow one cycle later.
REQ-036 Data scenario: req0 with a=16'h00F0 and b=16'h0F01 SHALL give rsp_data=16'h0FF1 and rsp_any=1 the next cycle; a=b=16'h0000 SHALL give rsp_data=16'h0000 and rsp_any=0.
REQ-037 Back-pressure scenario: with rsp_valid=1 and rsp_ready held 0 for 3 cycles, gnt SHALL be 0 and rsp_data and rsp_id SHALL stay stable; when rsp_ready=1, the grant SHALL resume in that same cycle.
REQ-038 Wrap scenario: with ptr=3 and req=4'b1001, gnt SHALL be 4'b0001; with ptr=0 and req=4'b1001, gnt SHALL be 4'b1000.
REQ-039 Mid-operation reset scenario: asserting rst asynchronously while rsp_valid=1 SHALL clear rsp_valid before the next clk edge, and the next grant after release SHALL go to requester 0 if req0=1.
REQ-040 Fairness scenario: with req=4'b0110 held for 10 cycles, the bench SHALL observe alternating grants 1,2,1,2,... and never two consecutive grants to the same requester.
